// File: rtl/stage_if_if.sv
// Instruction-fetch bus bundle: control inputs, instruction-memory port and IF/ID outputs.
// The master modport is the fetch stage; the slave modport is its environment.
interface stage_if_if #(
  parameter int ADDR_W = 10
);
  logic              stall;
  logic              isJumped;
  logic [31:0]       jumpAddr;
  logic              step_mode;
  logic              step;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic [31:0]       pc_id;
  logic              nop_if;
  logic              halted;
  logic [31:0]       instr_count;

  modport master (
    input  stall, isJumped, jumpAddr, step_mode, step, imem_rdata,
    output imem_addr, instr, pc_id, nop_if, halted, instr_count
  );

  modport slave (
    output stall, isJumped, jumpAddr, step_mode, step, imem_rdata,
    input  imem_addr, instr, pc_id, nop_if, halted, instr_count
  );
endinterface

// File: rtl/stage_if.sv
// MIPS instruction-fetch stage: PC, IF/ID register, redirect/flush, stall,
// HALT detection, debug single-step gating and a retired-fetch counter.
module stage_if #(
  parameter logic [31:0] PC_RESET    = 32'h0,
  parameter int          ADDR_W      = 10,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input logic        clock,
  input logic        reset,
  stage_if_if.master bus
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_id_reg;
  logic        nop_if_reg;
  logic        halted_reg;
  logic [31:0] count_reg;

  logic [31:0] pc_plus4;
  logic        is_halt;

  assign pc_plus4 = pc_reg + 32'd4;
  assign is_halt  = (bus.imem_rdata[31:26] == HALT_OPCODE);

  // Word address only; the low byte bits and the high bits alias in memory.
  assign bus.imem_addr = pc_reg[ADDR_W+1:2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= RUN;
      pc_reg     <= PC_RESET;
      instr_reg  <= 32'h0;
      pc_id_reg  <= 32'h0;
      nop_if_reg <= 1'b1;
      halted_reg <= 1'b0;
      count_reg  <= 32'h0;
    end else if (bus.isJumped) begin
      // Redirect beats everything, including a HALT fetched on the wrong path.
      pc_reg     <= bus.jumpAddr;
      instr_reg  <= 32'h0;
      pc_id_reg  <= 32'h0;
      nop_if_reg <= 1'b1;
      state_reg  <= RUN;
      halted_reg <= 1'b0;
    end else if (state_reg == HALTED) begin
      nop_if_reg <= 1'b1;
    end else if (bus.stall) begin
      nop_if_reg <= nop_if_reg;
    end else if (bus.step_mode && !bus.step) begin
      instr_reg  <= 32'h0;
      pc_id_reg  <= 32'h0;
      nop_if_reg <= 1'b1;
    end else if (is_halt) begin
      instr_reg  <= 32'h0;
      pc_id_reg  <= 32'h0;
      nop_if_reg <= 1'b1;
      state_reg  <= HALTED;
      halted_reg <= 1'b1;
    end else begin
      instr_reg  <= bus.imem_rdata;
      pc_id_reg  <= pc_plus4;
      nop_if_reg <= 1'b0;
      pc_reg     <= pc_plus4;
      count_reg  <= count_reg + 32'd1;
    end
  end

  assign bus.instr       = instr_reg;
  assign bus.pc_id       = pc_id_reg;
  assign bus.nop_if      = nop_if_reg;
  assign bus.halted      = halted_reg;
  assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: a behavioural model pushes expected IF/ID state
// into a queue each cycle; the queue is popped and compared after the edge.
module tb_stage_if;

  localparam int ADDR_W = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  stage_if_if #(.ADDR_W(ADDR_W)) bus ();

  stage_if #(
    .PC_RESET    (32'h0),
    .ADDR_W      (ADDR_W),
    .HALT_OPCODE (6'b111111)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  assign bus.imem_rdata = mem[bus.imem_addr];

  typedef struct packed {
    logic [31:0]       instr;
    logic [31:0]       pc_id;
    logic              nop_if;
    logic              halted;
    logic [31:0]       count;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pcid, m_cnt;
  logic        m_nop, m_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pcid = 32'h0; m_cnt = 32'h0;
    m_nop = 1'b1; m_halted = 1'b0;
    exp_q.delete();
  endtask

  // Applies the fetch rules to the model for the upcoming edge and queues the result.
  task automatic model_edge();
    logic [31:0] w;
    exp_t e;
    w = mem[m_pc[ADDR_W+1:2]];
    if (bus.isJumped) begin
      m_pc = bus.jumpAddr; m_instr = 32'h0; m_pcid = 32'h0; m_nop = 1'b1; m_halted = 1'b0;
    end else if (m_halted || bus.stall) begin
      // hold
    end else if (bus.step_mode && !bus.step) begin
      m_instr = 32'h0; m_pcid = 32'h0; m_nop = 1'b1;
    end else if (w[31:26] == 6'b111111) begin
      m_instr = 32'h0; m_pcid = 32'h0; m_nop = 1'b1; m_halted = 1'b1;
    end else begin
      m_instr = w; m_pcid = m_pc + 32'd4; m_nop = 1'b0;
      m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end
    e.instr = m_instr; e.pc_id = m_pcid; e.nop_if = m_nop;
    e.halted = m_halted; e.count = m_cnt; e.addr = m_pc[ADDR_W+1:2];
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    model_edge();
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      chk("instr", bus.instr, e.instr);
      chk("pc_id", bus.pc_id, e.pc_id);
      chk("nop_if", {31'h0, bus.nop_if}, {31'h0, e.nop_if});
      chk("halted", {31'h0, bus.halted}, {31'h0, e.halted});
      chk("instr_count", bus.instr_count, e.count);
      chk("imem_addr", {22'h0, bus.imem_addr}, {22'h0, e.addr});
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_instr"}, bus.instr, 32'h0);
    chk({tag, "_pc_id"}, bus.pc_id, 32'h0);
    chk({tag, "_nop_if"}, {31'h0, bus.nop_if}, 32'h1);
    chk({tag, "_halted"}, {31'h0, bus.halted}, 32'h0);
    chk({tag, "_count"}, bus.instr_count, 32'h0);
    chk({tag, "_imem_addr"}, {22'h0, bus.imem_addr}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] cnt_before;
    int          fetched;

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h20000000 + (i + 1) * 32'h00010001;
    bus.stall = 0; bus.isJumped = 0; bus.jumpAddr = 0; bus.step_mode = 0; bus.step = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk_reset_values("reset");
    reset = 0;

    // Sequential fetch, then a 3-cycle stall after the second fetch
    tick();
    chk("first_instr", bus.instr, 32'h20010001);
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1;
      tick();
      chk("stall_instr", bus.instr, 32'h20020002);
      chk("stall_pc_id", bus.pc_id, 32'h8);
      chk("stall_addr", {22'h0, bus.imem_addr}, 32'h2);
    end
    bus.stall = 0;
    tick();
    chk("resume_instr", bus.instr, 32'h20030003);
    tick();
    chk("count_4", bus.instr_count, 32'h4);

    // Redirect concurrent with stall
    bus.isJumped = 1; bus.jumpAddr = 32'h40; bus.stall = 1;
    tick();
    chk("jump_nop", {31'h0, bus.nop_if}, 32'h1);
    bus.isJumped = 0; bus.stall = 0;
    tick();
    chk("jump_target", bus.instr, 32'h20110011);
    chk("jump_pc_id", bus.pc_id, 32'h44);

    // HALT word at mem[4]
    mem[4] = 32'hFC000000;
    bus.isJumped = 1; bus.jumpAddr = 32'h0;
    tick();
    bus.isJumped = 0;
    repeat (5) tick();
    chk("halted", {31'h0, bus.halted}, 32'h1);
    chk("halt_addr", {22'h0, bus.imem_addr}, 32'h4);
    bus.step_mode = 1; bus.step = 1;
    repeat (3) tick();
    bus.step_mode = 0; bus.step = 0;
    bus.isJumped = 1; bus.jumpAddr = 32'h0;
    tick();
    chk("unhalt", {31'h0, bus.halted}, 32'h0);
    bus.isJumped = 0;
    mem[4] = 32'h20050005;
    tick();
    chk("restart_instr", bus.instr, 32'h20010001);

    // Single-step: two pulses five cycles apart
    cnt_before = m_cnt;
    fetched = 0;
    bus.step_mode = 1;
    for (int i = 0; i < 12; i++) begin
      bus.step = (i == 2 || i == 7);
      tick();
      if (!bus.nop_if) fetched++;
    end
    bus.step = 0; bus.step_mode = 0;
    chk("step_fetches", fetched, 32'd2);
    chk("step_count", bus.instr_count, cnt_before + 32'd2);

    // Asynchronous reset while HALTED
    mem[4] = 32'hFC000000;
    bus.isJumped = 1; bus.jumpAddr = 32'h0;
    tick();
    bus.isJumped = 0;
    repeat (6) tick();
    chk("pre_reset_halted", {31'h0, bus.halted}, 32'h1);
    #2;
    reset = 1;
    #1;
    chk_reset_values("async_reset");
    model_reset();
    @(posedge clock);
    #1;
    reset = 0;
    mem[4] = 32'h20050005;
    tick();
    chk("post_reset_instr", bus.instr, 32'h20010001);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
